alu_seq_ctrl: RTL and testbench

- Sequencer that time-shares one type-1 ALU instance across all NUM_SLOTS container slots of a PHV in one RMT stage.
- Accepts one PHV's worth of sub-actions and operands in a single valid/ready handshake.
- Issues non-empty slots to the ALU one at a time, collects each result and presents the full result vector with a single valid/ready handshake.
- Empty-opcode slots bypass the ALU (result = operand 1), saving cycles.

---
 rtl/alu_seq_ctrl_pkg.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared RMT stage definitions: sub-action opcode constants, opcode field placement
// and the ALU sequencer state encoding.
package alu_seq_ctrl_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP     = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD     = 4'b0001;
   localparam logic [OPC_W-1:0] OP_ADD_ALT = 4'b1001;
   localparam logic [OPC_W-1:0] OP_SUB     = 4'b0010;
   localparam logic [OPC_W-1:0] OP_SUB_ALT = 4'b1010;
   localparam logic [OPC_W-1:0] OP_SET     = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } ctrl_state_t;

   // The opcode occupies the top OPC_W bits of a sub-action.
   function automatic int opc_lsb(input int action_len);
      return action_len - OPC_W;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Time-shares one ALU across all PHV container slots: capture a vector, issue each non-empty
// slot, collect results. Empty slots bypass the ALU; a silent ALU is abandoned after TIMEOUT_CYCLES.
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int NUM_SLOTS      = 8,
   parameter int ACTION_LEN     = 25,
   parameter int DATA_WIDTH     = 48,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_SLOTS*ACTION_LEN-1:0] action_vec,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] op1_vec,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] op2_vec,
   output logic [ACTION_LEN-1:0]           alu_action,
   output logic                            alu_action_valid,
   output logic [DATA_WIDTH-1:0]           alu_op1,
   output logic [DATA_WIDTH-1:0]           alu_op2,
   input  logic [DATA_WIDTH-1:0]           alu_result,
   input  logic                            alu_result_valid,
   output logic [NUM_SLOTS*DATA_WIDTH-1:0] result_vec,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            timeout_err
);

   localparam int IDX_W   = $clog2(NUM_SLOTS);
   localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int OPC_LSB = opc_lsb(ACTION_LEN);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_t state_q, state_d;

   logic [IDX_W-1:0]                idx_q;
   logic [CNT_W-1:0]                wait_cnt_q;
   logic [NUM_SLOTS*ACTION_LEN-1:0] act_q;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] op1_q;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] op2_q;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] res_q;

   logic [ACTION_LEN-1:0] cur_act;
   logic [DATA_WIDTH-1:0] cur_op1;
   logic [DATA_WIDTH-1:0] cur_op2;
   logic                  slot_empty;
   logic                  last_slot;
   logic                  wait_expired;

   logic capture;
   logic issue_load;
   logic res_wr;
   logic res_from_alu;
   logic idx_inc;
   logic timeout_hit;
   logic slot_end;

   assign cur_act      = act_q[idx_q*ACTION_LEN +: ACTION_LEN];
   assign cur_op1      = op1_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
   assign cur_op2      = op2_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
   assign slot_empty   = (cur_act[OPC_LSB +: OPC_W] == OP_NOP);
   assign last_slot    = (idx_q == LAST_IDX);
   assign wait_expired = (wait_cnt_q == LAST_WAIT);

   assign in_ready   = (state_q == ST_IDLE);
   assign result_vec = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      issue_load   = 1'b0;
      res_wr       = 1'b0;
      res_from_alu = 1'b0;
      idx_inc      = 1'b0;
      timeout_hit  = 1'b0;
      slot_end     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               capture = 1'b1;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (slot_empty) begin
               res_wr   = 1'b1;
               slot_end = 1'b1;
            end else begin
               issue_load = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A result landing on the final wait cycle beats the timeout.
            if (alu_result_valid) begin
               res_wr       = 1'b1;
               res_from_alu = 1'b1;
               slot_end     = 1'b1;
            end else if (wait_expired) begin
               res_wr      = 1'b1;
               timeout_hit = 1'b1;
               slot_end    = 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (slot_end) begin
         if (last_slot) begin
            state_d = ST_DONE;
         end else begin
            idx_inc = 1'b1;
            state_d = ST_SCAN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q            <= '0;
         wait_cnt_q       <= '0;
         act_q            <= '0;
         op1_q            <= '0;
         op2_q            <= '0;
         res_q            <= '0;
         alu_action       <= '0;
         alu_op1          <= '0;
         alu_op2          <= '0;
         alu_action_valid <= 1'b0;
         out_valid        <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         if (capture) begin
            act_q <= action_vec;
            op1_q <= op1_vec;
            op2_q <= op2_vec;
            idx_q <= '0;
         end else if (idx_inc) begin
            idx_q <= idx_q + IDX_W'(1);
         end

         if (res_wr) begin
            res_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= res_from_alu ? alu_result : cur_op1;
         end

         // ALU operands stay put after the issue strobe until the next slot is loaded.
         if (issue_load) begin
            alu_action <= cur_act;
            alu_op1    <= cur_op1;
            alu_op2    <= cur_op2;
         end

         if (state_q == ST_ISSUE) begin
            wait_cnt_q <= '0;
         end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
         end

         alu_action_valid <= issue_load;
         out_valid        <= (state_d == ST_DONE);
         timeout_err      <= timeout_hit;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl: an ALU model with per-issue latency, plus a slot-level
// reference that predicts results, completion time and timeouts from the sub-actions alone.
module tb_alu_seq_ctrl;
   import alu_seq_ctrl_pkg::*;

   localparam int N  = 8;
   localparam int AL = 25;
   localparam int DW = 48;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*AL-1:0] action_vec = '0;
   logic [N*DW-1:0] op1_vec = '0;
   logic [N*DW-1:0] op2_vec = '0;
   logic [AL-1:0]   alu_action;
   logic            alu_action_valid;
   logic [DW-1:0]   alu_op1;
   logic [DW-1:0]   alu_op2;
   logic [DW-1:0]   alu_result = '0;
   logic            alu_result_valid = 1'b0;
   logic [N*DW-1:0] result_vec;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            timeout_err;

   alu_seq_ctrl #(.NUM_SLOTS(N), .ACTION_LEN(AL), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .action_vec(action_vec), .op1_vec(op1_vec), .op2_vec(op2_vec),
      .alu_action(alu_action), .alu_action_valid(alu_action_valid),
      .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result), .alu_result_valid(alu_result_valid),
      .result_vec(result_vec), .out_valid(out_valid), .out_ready(out_ready),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] alu_fn(input logic [AL-1:0] a, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
      case (a[AL-1 -: 4])
         OP_ADD, OP_ADD_ALT: return x + y;
         OP_SUB, OP_SUB_ALT: return x - y;
         OP_SET:             return y;
         default:            return x;
      endcase
   endfunction

   typedef struct {
      logic [AL-1:0] act;
      logic [DW-1:0] o1;
      logic [DW-1:0] o2;
      int            lat;
   } iss_t;

   iss_t exp_q[$];

   // Current stimulus vector; lat 0 means the ALU never answers that slot.
   logic [N*AL-1:0] v_act;
   logic [N*DW-1:0] v_op1;
   logic [N*DW-1:0] v_op2;
   int              v_lat[N];

   bit spur_on = 1'b0;
   int n_iss = 0;
   int n_to_seen = 0;
   int last_iss = 0;

   // ALU model: answers each issue after its latency, checks operand hold while waiting.
   iss_t          cur_e;
   logic [DW-1:0] rsp;
   logic [AL-1:0] h_act;
   logic [DW-1:0] h_o1, h_o2;
   int            due, stab, lat;
   bit            pend = 1'b0, prev_aav = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
         stab = 0;
         prev_aav = 1'b0;
         alu_result_valid = 1'b0;
         alu_result = '0;
      end else begin
         alu_result_valid = 1'b0;
         if (prev_aav) chk("strobe_w", 64'(alu_action_valid), 64'(0));
         if (timeout_err) begin
            n_to_seen++;
            chk("to_cyc", 64'(cyc - last_iss), 64'(TO + 1));
         end
         if (alu_action_valid && !prev_aav) begin
            n_iss++;
            last_iss = cyc;
            h_act = alu_action;
            h_o1 = alu_op1;
            h_o2 = alu_op2;
            lat = 5;
            if (exp_q.size() > 0) begin
               cur_e = exp_q.pop_front();
               chk("iss_act", 64'(alu_action), 64'(cur_e.act));
               chk("iss_op1", 64'(alu_op1), 64'(cur_e.o1));
               chk("iss_op2", 64'(alu_op2), 64'(cur_e.o2));
               lat = cur_e.lat;
            end
            rsp  = alu_fn(alu_action, alu_op1, alu_op2);
            pend = (lat != 0);
            due  = cyc + lat;
            stab = (lat >= 1 && lat <= TO) ? lat : TO;
         end else if (stab > 0) begin
            chk("hold_act", 64'(alu_action), 64'(h_act));
            chk("hold_op1", 64'(alu_op1), 64'(h_o1));
            chk("hold_op2", 64'(alu_op2), 64'(h_o2));
            stab--;
         end
         if (pend && cyc == due) begin
            alu_result_valid = 1'b1;
            alu_result = rsp;
            pend = 1'b0;
         end
         if (spur_on) begin
            alu_result_valid = 1'b1;
            alu_result = DW'({$urandom, $urandom});
         end
         prev_aav = alu_action_valid;
      end
   end

   task automatic start_vec(output int h);
      int t;
      @(negedge clk);
      action_vec = v_act;
      op1_vec = v_op1;
      op2_vec = v_op2;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("accept", 64'(in_ready), 64'(1));
      h = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input int hold, input bit spur);
      logic [DW-1:0]   exp_r[N];
      logic [AL-1:0]   a;
      logic [DW-1:0]   o1, o2;
      logic [N*DW-1:0] snap;
      int span, n_to_exp, n_iss_exp, h, t, to_base, iss_base;
      span = 1;
      n_to_exp = 0;
      n_iss_exp = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         a  = v_act[i*AL +: AL];
         o1 = v_op1[i*DW +: DW];
         o2 = v_op2[i*DW +: DW];
         if (a[AL-1 -: 4] == OP_NOP) begin
            exp_r[i] = o1;
            span += 1;
         end else begin
            exp_q.push_back('{act: a, o1: o1, o2: o2, lat: v_lat[i]});
            n_iss_exp++;
            if (v_lat[i] >= 1 && v_lat[i] <= TO) begin
               exp_r[i] = alu_fn(a, o1, o2);
               span += 2 + v_lat[i];
            end else begin
               exp_r[i] = o1;
               span += 2 + TO;
               n_to_exp++;
            end
         end
      end
      to_base = n_to_seen;
      iss_base = n_iss;
      spur_on = spur;
      start_vec(h);
      t = 0;
      while (!out_valid && t < 1000) begin
         @(negedge clk);
         t++;
      end
      spur_on = 1'b0;
      chk("done_lat", 64'(cyc - h), 64'(span));
      chk("n_iss", 64'(n_iss - iss_base), 64'(n_iss_exp));
      for (int i = 0; i < N; i++)
         chk($sformatf("res%0d", i), 64'(result_vec[i*DW +: DW]), 64'(exp_r[i]));
      snap = result_vec;
      for (int c = 0; c < hold; c++) begin
         if (c == 0) begin
            in_valid = 1'b1;
            action_vec = {N{AL'($urandom)}};
            op1_vec = {N{DW'({$urandom, $urandom})}};
         end
         spur_on = 1'b1;
         @(negedge clk);
         chk("hold_vld", 64'(out_valid), 64'(1));
         chk("hold_rdy", 64'(in_ready), 64'(0));
         chk("hold_res", 64'(result_vec == snap), 64'(1));
      end
      in_valid = 1'b0;
      spur_on = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rel_vld", 64'(out_valid), 64'(0));
      chk("rel_rdy", 64'(in_ready), 64'(1));
      chk("n_to", 64'(n_to_seen - to_base), 64'(n_to_exp));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rdy", 64'(in_ready), 64'(1));
      chk("rst_ovld", 64'(out_valid), 64'(0));
      chk("rst_aav", 64'(alu_action_valid), 64'(0));
      chk("rst_act", 64'(alu_action), 64'(0));
      chk("rst_op1", 64'(alu_op1), 64'(0));
      chk("rst_op2", 64'(alu_op2), 64'(0));
      chk("rst_to", 64'(timeout_err), 64'(0));
      chk("rst_res", 64'(result_vec == '0), 64'(1));
   endtask

   task automatic clear_vec();
      v_act = '0;
      v_op1 = '0;
      v_op2 = '0;
      for (int i = 0; i < N; i++) v_lat[i] = 5;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int h, t, iss_base, r;
      logic [3:0] opc;

      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;

      // All slots empty, ALU strobes spraying throughout: pure bypass.
      clear_vec();
      for (int i = 0; i < N; i++) begin
         v_op1[i*DW +: DW] = DW'(i + 1);
         v_op2[i*DW +: DW] = DW'($urandom);
      end
      run_vec(0, 1'b1);

      // ADD on slot 0, SUB on slot 3.
      clear_vec();
      for (int i = 0; i < N; i++) v_op1[i*DW +: DW] = DW'(20 + i);
      v_act[0*AL +: AL] = {OP_ADD, 21'h00123};
      v_op1[0*DW +: DW] = 48'd10;
      v_op2[0*DW +: DW] = 48'd5;
      v_act[3*AL +: AL] = {OP_SUB, 21'h1abcd};
      v_op1[3*DW +: DW] = 48'd100;
      v_op2[3*DW +: DW] = 48'd1;
      run_vec(0, 1'b0);

      // Silent ALU on slot 2, later slot completes; result held in DONE for 10 cycles.
      clear_vec();
      v_act[2*AL +: AL] = {OP_SET, 21'h0};
      v_op1[2*DW +: DW] = 48'd7;
      v_op2[2*DW +: DW] = 48'd99;
      v_lat[2] = 0;
      v_act[5*AL +: AL] = {OP_ADD_ALT, 21'h5};
      v_op1[5*DW +: DW] = 48'hffff_ffff_ffff;
      v_op2[5*DW +: DW] = 48'd2;
      run_vec(10, 1'b0);

      // Result on the last allowed wait cycle vs. one cycle too late.
      clear_vec();
      v_act[1*AL +: AL] = {OP_ADD, 21'h7};
      v_op1[1*DW +: DW] = 48'd1000;
      v_op2[1*DW +: DW] = 48'd234;
      v_lat[1] = TO;
      v_act[7*AL +: AL] = {OP_SUB_ALT, 21'h9};
      v_op1[7*DW +: DW] = 48'd55;
      v_op2[7*DW +: DW] = 48'd5;
      v_lat[7] = TO + 1;
      run_vec(0, 1'b0);

      // Reset while waiting on slot 1.
      clear_vec();
      v_act[0*AL +: AL] = {OP_ADD, 21'h1};
      v_act[1*AL +: AL] = {OP_ADD, 21'h2};
      v_op1 = {N{48'd3}};
      v_op2 = {N{48'd4}};
      exp_q.delete();
      iss_base = n_iss;
      start_vec(h);
      t = 0;
      while (n_iss < iss_base + 2 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("pre_rst_iss", 64'(n_iss - iss_base), 64'(2));
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      v_act[3*AL +: AL] = {OP_SUB, 21'h3};
      run_vec(0, 1'b0);

      // Randomized vectors.
      for (int v = 0; v < 25; v++) begin
         for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 7);
            case (r)
               3:       opc = OP_ADD;
               4:       opc = OP_ADD_ALT;
               5:       opc = OP_SUB;
               6:       opc = ($urandom_range(0, 1) == 0) ? OP_SUB_ALT : OP_SET;
               7:       opc = 4'($urandom_range(1, 15));
               default: opc = OP_NOP;
            endcase
            v_act[i*AL +: AL] = {opc, 21'($urandom)};
            v_op1[i*DW +: DW] = DW'({$urandom, $urandom});
            v_op2[i*DW +: DW] = DW'({$urandom, $urandom});
            r = $urandom_range(0, 11);
            v_lat[i] = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : r - 2;
         end
         run_vec($urandom_range(0, 2), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
